// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Instruction sequencer for the TinyCPU board top. A 2^DEPTH_LOG2-entry
// program buffer is filled from the instruction switches in LOAD mode. It is
// then replayed into the CPU one instruction at a time. In STEP mode each
// button press issues one word. In RUN mode one word is issued every RUN_DIV
// clocks. HOLD freezes sequencing. Fetching HALT_OP enters a sticky HALT
// state, which only LOAD (or reset) leaves. The instruction output is a
// register, so the CPU sees a stable word between issues.
//
// Parameters:
//   DEPTH_LOG2       program buffer address width (depth = 2^DEPTH_LOG2)
//   RUN_DIV          clocks between issues in RUN (>= 2)
//   HALT_OP          opcode that stops sequencing; never issued
//   DEBOUNCE_CYCLES  stable-level requirement on btn (debounce build only)
//
// Build option:
//   SEQ_DEBOUNCE_EN  when defined, the synchronized btn level must stay at a
//                    new value for DEBOUNCE_CYCLES cycles before the edge
//                    detector sees it. When undefined, no debounce counter
//                    exists.
//
// Ports:
//   clk        in   single clock
//   rst        in   synchronous active-high reset
//   sw[7:0]    in   instruction switches (async), sampled at the write event
//   mode[1:0]  in   mode switches (async): 00 LOAD, 01 STEP, 10 RUN, 11 HOLD
//   btn        in   load/step push button (async, raw level)
//   instr[7:0] out  registered instruction to the CPU
//   issue      out  one-cycle strobe; instr changed this cycle
//   pc         out  index of the next word to issue
//   prog_len   out  number of valid words loaded (0..DEPTH)
//   halted     out  HALT_OP reached
//   dbg_state  out  current FSM state encoding (state_t)
//
// Handshake: there is no back-pressure. issue is a pure strobe that is
// qualified by nothing. The CPU must accept instr on every cycle in which
// issue is 1.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int         DEPTH_LOG2      = 4,
  parameter int         RUN_DIV         = 25_000_000,
  parameter logic [7:0] HALT_OP         = 8'hFF,
  parameter int         DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            sw,
  input  logic [1:0]            mode,
  input  logic                  btn,
  output logic [7:0]            instr,
  output logic                  issue,
  output logic [DEPTH_LOG2-1:0] pc,
  output logic [DEPTH_LOG2:0]   prog_len,
  output logic                  halted,
  output logic [2:0]            dbg_state
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  PLW      = DEPTH_LOG2 + 1;
  localparam logic [PLW-1:0]      DEPTH_PL = PLW'(DEPTH);
  localparam int                  DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_TC   = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_STEP = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t state, state_n, want;

  // Input conditioning
  logic [1:0] mode_s1, mode_s2;
  logic       btn_s1, btn_s2;
  logic       btn_lvl;       // level seen by the edge detector
  logic       btn_prev;
  logic       btn_ev;        // registered, one cycle wide

  // Datapath state
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DIV_W-1:0]      div_cnt;

  // Decoded control
  logic                  mode_chg;
  logic                  fetch;
  logic                  do_issue;
  logic                  do_write;
  logic [7:0]            word;
  logic [DEPTH_LOG2-1:0] pc_next;

  // -------------------------------------------------------------------------
  // Synchronizers and button edge detect
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s1 <= 2'b00;
      mode_s2 <= 2'b00;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  localparam int             DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            btn_f;

  // The counter runs only while the synchronized level differs from the
  // filtered level. Any return to the filtered level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_f  <= 1'b0;
    end else if (btn_s2 != btn_f) begin
      if (db_cnt == DB_TC) begin
        btn_f  <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_lvl = btn_f;
`else
  logic [31:0] unused_debounce;
  assign unused_debounce = DEBOUNCE_CYCLES;
  assign btn_lvl         = btn_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= 1'b0;
      btn_ev   <= 1'b0;
    end else begin
      btn_prev <= btn_lvl;
      btn_ev   <= btn_lvl & ~btn_prev;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  // -------------------------------------------------------------------------
  // Next state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    want     = S_LOAD;
    state_n  = state;
    mode_chg = 1'b0;
    fetch    = 1'b0;
    do_issue = 1'b0;
    do_write = 1'b0;
    word     = mem[pc];
    pc_next  = pc + 1'b1;

    case (mode_s2)
      2'b00:   want = S_LOAD;
      2'b01:   want = S_STEP;
      2'b10:   want = S_RUN;
      default: want = S_HOLD;
    endcase

    // HALT is sticky except toward LOAD. A mode change consumes the cycle,
    // so a button event or terminal count in the same cycle is dropped.
    if (state == S_HALT) begin
      if (want == S_LOAD) begin
        state_n  = S_LOAD;
        mode_chg = 1'b1;
      end
    end else if (want != state) begin
      state_n  = want;
      mode_chg = 1'b1;
    end

    // An empty program never fetches, so stale memory is never seen.
    if (!mode_chg && (prog_len != '0)) begin
      if ((state == S_STEP) && btn_ev)          fetch = 1'b1;
      if ((state == S_RUN) && (div_cnt == DIV_TC)) fetch = 1'b1;
    end

    if (fetch) begin
      if (word == HALT_OP) state_n  = S_HALT;
      else                 do_issue = 1'b1;
    end

    do_write = !mode_chg && (state == S_LOAD) && btn_ev;

    // The program wraps at its loaded length, not at the buffer depth.
    if (({1'b0, pc} + PLW'(1)) == prog_len) pc_next = '0;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= 8'h00;
      issue    <= 1'b0;
      pc       <= '0;
      prog_len <= '0;
      wptr     <= '0;
      div_cnt  <= '0;
    end else begin
      issue <= do_issue;

      if (do_issue) instr <= word;

      if (mode_chg && (state == S_LOAD) &&
          ((state_n == S_STEP) || (state_n == S_RUN)))
        pc <= '0;
      else if (do_issue)
        pc <= pc_next;

      if (mode_chg && (state_n == S_LOAD)) begin
        wptr     <= '0;
        prog_len <= '0;
      end else if (do_write) begin
        wptr <= wptr + 1'b1;  // wraps at DEPTH and overwrites from word 0
        if (prog_len != DEPTH_PL) prog_len <= prog_len + 1'b1;
      end

      // The divider only advances in RUN, so it is frozen in HOLD.
      if (mode_chg)
        div_cnt <= '0;
      else if (state == S_RUN)
        div_cnt <= (div_cnt == DIV_TC) ? '0 : div_cnt + 1'b1;
    end
  end

  // Program buffer has no reset. prog_len guards its contents.
  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= sw;
  end

  assign halted    = (state == S_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer with RUN_DIV=4 and DEPTH_LOG2=4. A
// negedge monitor checks every issue strobe against the expected-instruction
// queue. The same monitor checks that instr never moves without issue.
// Directed steps then check reset values, latencies, HALT, HOLD, overflow and
// the empty program. Debounce steps are built only when SEQ_DEBOUNCE_EN is
// defined (DEBOUNCE_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int DL2 = 4;
`ifdef SEQ_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]     sw   = 8'h00;
  logic [1:0]     mode = 2'b00;
  logic           btn  = 1'b0;
  logic [7:0]     instr;
  logic           issue;
  logic [DL2-1:0] pc;
  logic [DL2:0]   prog_len;
  logic           halted;
  logic [2:0]     dbg_state;

  cpu_sequencer #(
    .DEPTH_LOG2(DL2),
    .RUN_DIV(4),
    .HALT_OP(8'hFF),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .mode(mode),
    .btn(btn),
    .instr(instr),
    .issue(issue),
    .pc(pc),
    .prog_len(prog_len),
    .halted(halted),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] prev_instr = 8'h00;
  logic [7:0] mon_exp;
  int n_assert  = 0;
  int n_fail    = 0;
  int issue_cnt = 0;
  int cnt_snap  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_instr = instr;
    end else begin
      if (issue === 1'b1) begin
        issue_cnt++;
        check("issue_was_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("scoreboard_instr", instr, mon_exp);
        end
      end else begin
        check("instr_stable", instr, prev_instr);
      end
      prev_instr = instr;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    tick(4);
  endtask

  task automatic load_press(input logic [7:0] v);
    sw  = v;
    btn = 1'b1;
    tick(4 + DB);
    btn = 1'b0;
    tick(4 + DB);
  endtask

  // Press in STEP with exact latency: issue rises 3(+DB) edges after btn is
  // first sampled high.
  task automatic step_press(input logic [7:0] e_instr, input logic [31:0] e_pc);
    exp_q.push_back(e_instr);
    btn = 1'b1;
    tick(3 + DB);
    check("step_issue_early", issue, 1'b0);
    tick(1);
    check("step_issue", issue, 1'b1);
    check("step_instr", instr, e_instr);
    check("step_pc", pc, e_pc);
    tick(1);
    check("step_issue_one_cycle", issue, 1'b0);
    btn = 1'b0;
    tick(4 + DB);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(2);
    check("rst_instr", instr, 8'h00);
    check("rst_issue", issue, 1'b0);
    check("rst_pc", pc, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_halted", halted, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    tick(2);

    // Load three words
    load_press(8'h12);
    load_press(8'h34);
    load_press(8'h56);
    check("load_prog_len", prog_len, 3);
    check("load_instr_held", instr, 8'h00);
    check("load_no_issue", issue_cnt, 0);

    // Step and wrap
    set_mode(2'b01);
    check("step_state", dbg_state, 3'd1);
    step_press(8'h12, 1);
    step_press(8'h34, 2);
    step_press(8'h56, 0);
    step_press(8'h12, 1);

    // Run with HALT
    set_mode(2'b00);
    check("reload_prog_len_clear", prog_len, 0);
    load_press(8'h01);
    load_press(8'h02);
    load_press(8'hFF);
    check("run_prog_len", prog_len, 3);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    mode = 2'b10;
    tick(6);
    check("run_first_early", issue, 1'b0);
    tick(1);
    check("run_issue_t", issue, 1'b1);
    check("run_instr_t", instr, 8'h01);
    check("run_pc_t", pc, 1);
    tick(3);
    check("run_gap", issue, 1'b0);
    tick(1);
    check("run_issue_t4", issue, 1'b1);
    check("run_instr_t4", instr, 8'h02);
    check("run_pc_t4", pc, 2);
    tick(3);
    check("run_not_halted_yet", halted, 1'b0);
    tick(1);
    check("halt_t8", halted, 1'b1);
    check("halt_no_issue", issue, 1'b0);
    check("halt_instr_held", instr, 8'h02);
    cnt_snap = issue_cnt;
    tick(8);
    check("halt_stays", halted, 1'b1);
    check("halt_no_more_issue", issue_cnt, cnt_snap);
    set_mode(2'b01);
    check("halt_step_sticky", halted, 1'b1);
    load_press(8'h00);
    check("halt_btn_ignored", issue_cnt, cnt_snap);
    set_mode(2'b00);
    check("halt_cleared_by_load", halted, 1'b0);
    check("halt_load_prog_len", prog_len, 0);

    // HOLD freeze
    load_press(8'hA1);
    load_press(8'hA2);
    load_press(8'hA3);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    mode = 2'b10;
    tick(7);
    check("hold_run_issue", issue, 1'b1);
    check("hold_run_pc", pc, 1);
    mode = 2'b11;
    tick(3);
    check("hold_state", dbg_state, 3'd3);
    cnt_snap = issue_cnt;
    tick(20);
    check("hold_no_issue", issue_cnt, cnt_snap);
    check("hold_pc_frozen", pc, 1);
    mode = 2'b10;
    tick(6);
    check("hold_resume_early", issue, 1'b0);
    tick(1);
    check("hold_resume_issue", issue, 1'b1);
    check("hold_resume_instr", instr, 8'hA2);
    check("hold_resume_pc", pc, 2);

    // Overflow: 17 writes, last one overwrites word 0
    mode = 2'b00;
    tick(4);
    check("ovf_prog_len_clear", prog_len, 0);
    for (int i = 0; i < 17; i++) begin
      load_press(8'(i));
      if (i == 15) check("ovf_prog_len_full", prog_len, 16);
    end
    check("ovf_prog_len_sat", prog_len, 16);
    set_mode(2'b01);
    check("ovf_pc_reset", pc, 0);
    step_press(8'h10, 1);
    step_press(8'h01, 2);

`ifdef SEQ_DEBOUNCE_EN
    // Debounce: a 5-cycle glitch is filtered, a 12-cycle press is one issue
    cnt_snap = issue_cnt;
    btn = 1'b1;
    tick(5);
    btn = 1'b0;
    tick(20);
    check("db_glitch_no_issue", issue_cnt, cnt_snap);
    check("db_glitch_pc", pc, 2);
    exp_q.push_back(8'h02);
    btn = 1'b1;
    tick(12);
    btn = 1'b0;
    tick(20);
    check("db_press_one_issue", issue_cnt, cnt_snap + 1);
    check("db_press_instr", instr, 8'h02);
    check("db_press_pc", pc, 3);
`endif

    // Empty program
    set_mode(2'b00);
    check("empty_prog_len", prog_len, 0);
    set_mode(2'b01);
    cnt_snap = issue_cnt;
    btn = 1'b1;
    tick(4 + DB);
    check("empty_no_issue_strobe", issue, 1'b0);
    btn = 1'b0;
    tick(4 + DB);
    check("empty_no_issue", issue_cnt, cnt_snap);
    check("empty_pc", pc, 0);
    check("empty_not_halted", halted, 1'b0);

    // Final report
    tick(2);
    check("exp_q_drained", exp_q.size(), 0);
    check("issue_total", issue_cnt, 10 + ((DB != 0) ? 1 : 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
